// File: rtl/msj_ctrl_pkg.sv
// Shared types and constants for the character-message sequencing controller.
package msj_ctrl_pkg;

    localparam int MSJ_W = 8;

    localparam logic SRC_BTN  = 1'b0;
    localparam logic SRC_AUTO = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        WAIT,
        HOLD,
        RESTART
    } state_t;

endpackage

// File: rtl/msj_auto_timer.sv
// Periodic auto-advance request: one-cycle tick every AUTO_PERIOD cycles while en is high.
// Dropping en clears the count, so re-enabling restarts a full period.
module msj_auto_timer #(
    parameter int AUTO_PERIOD = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(AUTO_PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(AUTO_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/msj_ctrl.sv
// Arbitrates button/auto advance requests, pulses step, captures msj_f and hands it out on valid/ready.
// The auto-advance timer exists only when MSJ_AUTO_EN is defined; otherwise only the button advances.
module msj_ctrl
    import msj_ctrl_pkg::*;
#(
    parameter int MSG_LEN     = 6,
    parameter int AUTO_PERIOD = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             M,
    input  logic             auto_en,
    input  logic [MSJ_W-1:0] msj_f,
    input  logic             msj_ready,
    output logic             step,
    output logic             fsm_rst,
    output logic [MSJ_W-1:0] msj_out,
    output logic             msj_valid,
    output logic             msj_src,
    output logic             busy
);

    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [MSJ_W-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             src_q, src_d;
    logic             last_q, last_d;
    logic             s1_q, s2_q, s3_q;
    logic             pend_btn_q, pend_btn_d;
    logic             pend_auto_q, pend_auto_d;
    logic             btn_req, auto_req;
    logic             grant_btn, grant_auto;

    assign btn_req = s2_q & ~s3_q;

`ifdef MSJ_AUTO_EN
    msj_auto_timer #(.AUTO_PERIOD(AUTO_PERIOD)) u_auto_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (auto_en),
        .tick (auto_req)
    );
`else
    localparam int unused_auto_period = AUTO_PERIOD;
    logic unused_auto_en;
    assign unused_auto_en = auto_en;
    assign auto_req       = 1'b0;
`endif

    // A request landing on an already-set flag merges into it (one deep).
    assign pend_btn_d  = btn_req  | (pend_btn_q  & ~grant_btn);
    assign pend_auto_d = auto_req | (pend_auto_q & ~grant_auto);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_d      = out_q;
        valid_d    = valid_q;
        src_d      = src_q;
        last_d     = last_q;
        grant_btn  = 1'b0;
        grant_auto = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie, serve whichever source lost the previous grant.
                if (pend_btn_q && (!pend_auto_q || last_q == SRC_AUTO)) begin
                    grant_btn = 1'b1;
                    src_d     = SRC_BTN;
                    last_d    = SRC_BTN;
                    state_d   = STEP;
                end else if (pend_auto_q) begin
                    grant_auto = 1'b1;
                    src_d      = SRC_AUTO;
                    last_d     = SRC_AUTO;
                    state_d    = STEP;
                end
            end
            STEP: state_d = WAIT;
            WAIT: begin
                out_d   = msj_f;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (msj_ready) begin
                    valid_d = 1'b0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = RESTART;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = IDLE;
                    end
                end
            end
            RESTART: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            src_q       <= SRC_BTN;
            last_q      <= SRC_AUTO;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            pend_btn_q  <= 1'b0;
            pend_auto_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            src_q       <= src_d;
            last_q      <= last_d;
            s1_q        <= M;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            pend_btn_q  <= pend_btn_d;
            pend_auto_q <= pend_auto_d;
        end
    end

    assign step      = (state_q == STEP);
    assign fsm_rst   = (state_q == RESTART);
    assign busy      = (state_q != IDLE);
    assign msj_out   = out_q;
    assign msj_valid = valid_q;
    assign msj_src   = src_q;

endmodule

// File: tb/tb_msj_ctrl.sv
// Directed bench for msj_ctrl with a stub message FSM that counts up from 8'h40 on each step.
module tb_msj_ctrl;

    localparam int MSG_LEN = 6;
`ifdef MSJ_AUTO_EN
    localparam int AUTO_PERIOD = 4;
`else
    localparam int AUTO_PERIOD = 100;
`endif

    logic       clk, rst, M, auto_en, msj_ready;
    logic [7:0] msj_f, msj_out, fsm_ch;
    logic       step, fsm_rst, msj_valid, msj_src, busy;
    int         errors = 0;
    int         checks = 0;

    msj_ctrl #(.MSG_LEN(MSG_LEN), .AUTO_PERIOD(AUTO_PERIOD)) dut (
        .clk       (clk),
        .rst       (rst),
        .M         (M),
        .auto_en   (auto_en),
        .msj_f     (msj_f),
        .msj_ready (msj_ready),
        .step      (step),
        .fsm_rst   (fsm_rst),
        .msj_out   (msj_out),
        .msj_valid (msj_valid),
        .msj_src   (msj_src),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst)          fsm_ch <= 8'h40;
        else if (fsm_rst) fsm_ch <= 8'h40;
        else if (step)    fsm_ch <= fsm_ch + 8'h01;
    end
    assign msj_f = fsm_ch;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; M = 1'b0; msj_ready = 1'b1; auto_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; M = 1'b0; msj_ready = 1'b1; auto_en = 1'b0;
        tick(); tick();
        checks++; if (step !== 1'b0)      begin errors++; $display("FAIL reset_step: got %b expected 0", step); end
        checks++; if (fsm_rst !== 1'b0)   begin errors++; $display("FAIL reset_fsm_rst: got %b expected 0", fsm_rst); end
        checks++; if (msj_out !== 8'h00)  begin errors++; $display("FAIL reset_out: got %h expected 00", msj_out); end
        checks++; if (msj_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", msj_valid); end
        checks++; if (msj_src !== 1'b0)   begin errors++; $display("FAIL reset_src: got %b expected 0", msj_src); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_press();
        int stepcnt;
        do_reset();
        stepcnt = 0;
        M = 1'b1;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (step === 1'b1) stepcnt++;
            if (e == 2) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_e2: got %b expected 0", busy); end
            end
            if (e == 3) begin
                checks++; if (step !== 1'b1) begin errors++; $display("FAIL single_step_e3: got %b expected 1", step); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_e3: got %b expected 1", busy); end
            end
            if (e == 4) begin
                checks++; if (msj_valid !== 1'b0) begin errors++; $display("FAIL single_valid_e4: got %b expected 0", msj_valid); end
            end
            if (e == 5) begin
                checks++; if (msj_valid !== 1'b1) begin errors++; $display("FAIL single_valid_e5: got %b expected 1", msj_valid); end
                checks++; if (msj_out !== 8'h41)  begin errors++; $display("FAIL single_out: got %h expected 41", msj_out); end
                checks++; if (msj_src !== 1'b0)   begin errors++; $display("FAIL single_src: got %b expected 0", msj_src); end
            end
            if (e == 6) begin
                checks++; if (msj_valid !== 1'b0) begin errors++; $display("FAIL single_valid_e6: got %b expected 0", msj_valid); end
            end
            if (e == 9) M = 1'b0;
        end
        checks++; if (stepcnt != 1) begin errors++; $display("FAIL single_step_count: got %0d expected 1", stepcnt); end
    endtask

    task automatic test_full_message();
        int vcnt, rcnt, hs_total;
        logic [7:0] got, exp_ch;
        do_reset();
        hs_total = 0;
        for (int p = 0; p < 7; p++) begin
            vcnt = 0; rcnt = 0; got = 8'h00;
            exp_ch = (p == 6) ? 8'h41 : 8'h41 + 8'(p);
            M = 1'b1;
            for (int t = 0; t < 14; t++) begin
                tick();
                if (t == 2) M = 1'b0;
                if (msj_valid === 1'b1) begin
                    if (vcnt == 0) got = msj_out;
                    vcnt++;
                end
                if (fsm_rst === 1'b1) rcnt++;
            end
            if (p < 6) hs_total += vcnt;
            checks++; if (got !== exp_ch) begin errors++; $display("FAIL msg_char[%0d]: got %h expected %h", p, got, exp_ch); end
            checks++; if (vcnt != 1) begin errors++; $display("FAIL msg_valid_cycles[%0d]: got %0d expected 1", p, vcnt); end
            checks++; if (rcnt != ((p == 5) ? 1 : 0)) begin
                errors++; $display("FAIL msg_fsm_rst[%0d]: got %0d expected %0d", p, rcnt, (p == 5) ? 1 : 0);
            end
        end
        checks++; if (hs_total != 6) begin errors++; $display("FAIL msg_handshakes: got %0d expected 6", hs_total); end
    endtask

    task automatic test_backpressure();
        int unstable, stepcnt, vcnt;
        bit seen;
        logic [7:0] got;
        do_reset();
        msj_ready = 1'b0;
        M = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            if (t == 2) M = 1'b0;
            if (msj_valid === 1'b1) seen = 1'b1;
        end
        M = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL bp_valid_timeout: got no valid expected valid within 20 cycles"); end
        checks++; if (msj_out !== 8'h41) begin errors++; $display("FAIL bp_first_out: got %h expected 41", msj_out); end
        unstable = 0; stepcnt = 0;
        for (int t = 0; t < 20; t++) begin
            if (t == 0) M = 1'b1;
            if (t == 3) M = 1'b0;
            if (msj_valid !== 1'b1 || msj_out !== 8'h41) unstable++;
            if (step === 1'b1) stepcnt++;
            tick();
        end
        checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable); end
        checks++; if (stepcnt != 0)  begin errors++; $display("FAIL bp_stall_steps: got %0d expected 0", stepcnt); end
        msj_ready = 1'b1;
        tick();
        checks++; if (msj_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", msj_valid); end
        stepcnt = 0; vcnt = 0; got = 8'h00;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (step === 1'b1) stepcnt++;
            if (msj_valid === 1'b1) begin vcnt++; got = msj_out; end
        end
        checks++; if (stepcnt != 1)  begin errors++; $display("FAIL bp_second_steps: got %0d expected 1", stepcnt); end
        checks++; if (vcnt != 1)     begin errors++; $display("FAIL bp_second_valid: got %0d expected 1", vcnt); end
        checks++; if (got !== 8'h42) begin errors++; $display("FAIL bp_second_out: got %h expected 42", got); end
    endtask

    task automatic test_reset_mid_hold();
        int vcnt;
        bit seen;
        logic [7:0] got;
        do_reset();
        msj_ready = 1'b0;
        M = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            if (t == 2) M = 1'b0;
            if (msj_valid === 1'b1) seen = 1'b1;
        end
        M = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL rh_valid_timeout: got no valid expected valid within 20 cycles"); end
        rst = 1'b1;
        #1;
        checks++; if (msj_valid !== 1'b0) begin errors++; $display("FAIL rh_valid: got %b expected 0", msj_valid); end
        checks++; if (msj_out !== 8'h00)  begin errors++; $display("FAIL rh_out: got %h expected 00", msj_out); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rh_busy: got %b expected 0", busy); end
        checks++; if ({step, fsm_rst, msj_src} !== 3'b000) begin
            errors++; $display("FAIL rh_misc: got %b expected 000", {step, fsm_rst, msj_src});
        end
        tick();
        rst = 1'b0; msj_ready = 1'b1;
        tick(); tick();
        vcnt = 0; got = 8'h00;
        M = 1'b1;
        for (int t = 0; t < 14; t++) begin
            tick();
            if (t == 2) M = 1'b0;
            if (msj_valid === 1'b1) begin vcnt++; got = msj_out; end
        end
        checks++; if (got !== 8'h41) begin errors++; $display("FAIL rh_after_out: got %h expected 41", got); end
        checks++; if (vcnt != 1)     begin errors++; $display("FAIL rh_after_valid: got %0d expected 1", vcnt); end
    endtask

`ifdef MSJ_AUTO_EN
    task automatic test_tie();
        int n;
        logic [1:0] srcs;
        do_reset();
        auto_en = 1'b1;
        tick();
        M = 1'b1;
        n = 0; srcs = 2'b11;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (t == 2) M = 1'b0;
            if (msj_valid === 1'b1) begin
                if (n < 2) srcs[n] = msj_src;
                n++;
            end
        end
        auto_en = 1'b0;
        checks++; if (n < 2)          begin errors++; $display("FAIL tie_count: got %0d expected at least 2", n); end
        checks++; if (srcs[0] !== 1'b0) begin errors++; $display("FAIL tie_first_src: got %b expected 0", srcs[0]); end
        checks++; if (srcs[1] !== 1'b1) begin errors++; $display("FAIL tie_second_src: got %b expected 1", srcs[1]); end
    endtask
`else
    task automatic test_no_auto();
        int stepcnt, vcnt;
        do_reset();
        auto_en = 1'b1;
        stepcnt = 0; vcnt = 0;
        for (int t = 0; t < 500; t++) begin
            tick();
            if (step === 1'b1) stepcnt++;
            if (msj_valid === 1'b1) vcnt++;
        end
        auto_en = 1'b0;
        checks++; if (stepcnt != 0) begin errors++; $display("FAIL noauto_steps: got %0d expected 0", stepcnt); end
        checks++; if (vcnt != 0)    begin errors++; $display("FAIL noauto_valid: got %0d expected 0", vcnt); end
    endtask
`endif

    initial begin
        rst = 1'b1; M = 1'b0; auto_en = 1'b0; msj_ready = 1'b1;
        test_reset();
        test_single_press();
        test_full_message();
        test_backpressure();
        test_reset_mid_hold();
`ifdef MSJ_AUTO_EN
        test_tie();
`else
        test_no_auto();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
